// File: rtl/vx_tcu_drl_max_exp_seq.sv
// Multi-beat TCU max-exponent aligner: collects a masked exponent group,
// then replays it beat by beat as per-lane shifts from the group max.
module vx_tcu_drl_max_exp_seq #(
  parameter int N      = 5,
  parameter int WIDTH  = 8,
  parameter int BEATS  = 4,
  parameter int SHIFTW = 8,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*WIDTH-1:0]    in_exps,
  input  logic [N-1:0]          in_mask,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_max_exp,
  output logic [N*SHIFTW-1:0]   out_shift,
  output logic [BW-1:0]         out_beat,
  output logic                  out_last,
  output logic                  out_all_masked
);

  typedef enum logic {COLLECT, DRAIN} state_e;

  state_e state_q, state_d;

  logic [BW-1:0] wr_cnt;
  logic [BW-1:0] rd_idx;
  logic [BW-1:0] nb_last;

  logic signed [WIDTH-1:0] max_q;
  logic max_vld;

  logic [N*WIDTH-1:0] exps_buf [BEATS];
  logic [N-1:0]       mask_buf [BEATS];

  logic accept, grp_end, xfer, drain_end;

  logic signed [WIDTH:0] bmax;
  logic bany;
  logic signed [WIDTH:0] mmax;
  logic mvld;

  logic load;
  logic [BW-1:0] ld_idx;
  logic [N*WIDTH-1:0] ld_exps;
  logic [N-1:0] ld_mask;
  logic signed [WIDTH-1:0] ld_max;
  logic ld_vld;
  logic ld_last;
  logic [N*SHIFTW-1:0] ld_shift;

  logic unused_mmax_msb;
  assign unused_mmax_msb = mmax[WIDTH];

  // saturating shift = max - exp; inactive lanes flush to all ones
  function automatic logic [SHIFTW-1:0] lane_shift(
    input logic signed [WIDTH:0] mx,
    input logic signed [WIDTH:0] ex,
    input logic act
  );
    logic [WIDTH:0] diff;
    logic [WIDTH+SHIFTW:0] d;
    diff = mx - ex;
    d = {{SHIFTW{1'b0}}, diff};
    if (!act || d > {{(WIDTH+1){1'b0}}, {SHIFTW{1'b1}}})
      return '1;
    return d[SHIFTW-1:0];
  endfunction

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == DRAIN);
  assign out_beat  = rd_idx;

  assign accept    = in_valid & in_ready;
  assign grp_end   = accept & (in_last | (wr_cnt == BW'(BEATS-1)));
  assign xfer      = out_valid & out_ready;
  assign drain_end = xfer & out_last;

  // max over active lanes of the incoming beat, merged with running max
  always_comb begin
    logic signed [WIDTH:0] e;
    bmax = '0;
    bany = 1'b0;
    e    = '0;
    for (int i = 0; i < N; i++) begin
      e = $signed(in_exps[i*WIDTH +: WIDTH]);
      if (in_mask[i] && (!bany || e > bmax)) begin
        bmax = e;
        bany = 1'b1;
      end
    end
    mmax = $signed(max_q);
    mvld = max_vld;
    if (bany && (!max_vld || bmax > mmax)) begin
      mmax = bmax;
      mvld = 1'b1;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (grp_end) state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = COLLECT;
    endcase
  end

  // select the beat to present next and derive its shifts
  always_comb begin
    load    = 1'b0;
    ld_idx  = '0;
    ld_exps = exps_buf[0];
    ld_mask = mask_buf[0];
    ld_max  = max_q;
    ld_vld  = max_vld;
    ld_last = 1'b0;
    if (grp_end) begin
      load   = 1'b1;
      ld_max = mmax[WIDTH-1:0];
      ld_vld = mvld;
      if (wr_cnt == '0) begin
        ld_exps = in_exps;
        ld_mask = in_mask;
        ld_last = 1'b1;
      end
    end else if (xfer && !out_last) begin
      load    = 1'b1;
      ld_idx  = rd_idx + BW'(1);
      ld_exps = exps_buf[ld_idx];
      ld_mask = mask_buf[ld_idx];
      ld_last = (ld_idx == nb_last);
    end
    for (int i = 0; i < N; i++) begin
      ld_shift[i*SHIFTW +: SHIFTW] = lane_shift(
        $signed(ld_max),
        $signed(ld_exps[i*WIDTH +: WIDTH]),
        ld_mask[i] & ld_vld);
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  // counters and running max
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt  <= '0;
      rd_idx  <= '0;
      nb_last <= '0;
      max_q   <= '0;
      max_vld <= 1'b0;
    end else begin
      if (accept) begin
        wr_cnt  <= wr_cnt + BW'(1);
        max_q   <= mmax[WIDTH-1:0];
        max_vld <= mvld;
      end
      if (grp_end) nb_last <= wr_cnt;
      if (load) rd_idx <= ld_idx;
      if (drain_end) begin
        wr_cnt  <= '0;
        rd_idx  <= '0;
        max_q   <= '0;
        max_vld <= 1'b0;
      end
    end
  end

  // exponent and mask buffer
  always_ff @(posedge clk) begin
    if (accept) begin
      exps_buf[wr_cnt] <= in_exps;
      mask_buf[wr_cnt] <= in_mask;
    end
  end

  // registered output beat
  always_ff @(posedge clk) begin
    if (reset || drain_end) begin
      out_max_exp    <= '0;
      out_shift      <= '0;
      out_last       <= 1'b0;
      out_all_masked <= 1'b0;
    end else if (load) begin
      out_max_exp    <= ld_vld ? ld_max : '0;
      out_shift      <= ld_shift;
      out_last       <= ld_last;
      out_all_masked <= !ld_vld;
    end
  end

endmodule
